// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register and req/ack instruction-memory port.
// Optional: define DELAY_SLOT_EN to issue the word after a taken branch instead of squashing it.
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        d_valid
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        req_en_q, req_en_d;
`ifdef DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  logic        redirect;
  logic        id_hold;
  logic        fire;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = d_valid_q && !stall && (pcsource != 2'b00);
    id_hold  = stall && d_valid_q;
    fire     = imem_req && imem_ack;
    pc_plus4 = pc_q + 32'd4;
    case (pcsource)
      2'b01:   target = {bpc[31:2], 2'b00};
      2'b10:   target = {ra[31:2], 2'b00};
      default: target = {jpc[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      dpc4_q      <= 32'd0;
      inst_q      <= NOP_INST;
      d_valid_q   <= 1'b0;
      buf_inst_q  <= 32'd0;
      buf_pc4_q   <= 32'd0;
      drop_addr_q <= 32'd0;
      req_en_q    <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dpc4_q      <= dpc4_d;
      inst_q      <= inst_d;
      d_valid_q   <= d_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc4_q   <= buf_pc4_d;
      drop_addr_q <= drop_addr_d;
      req_en_q    <= req_en_d;
`ifdef DELAY_SLOT_EN
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
`endif
    end
  end

  // A redirect with a request still waiting for its ack must finish that handshake in S_DROP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
`ifdef DELAY_SLOT_EN
          state_d = S_REQ;
`else
          state_d = (imem_req && !imem_ack) ? S_DROP : S_REQ;
`endif
        end else if (fire && id_hold) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (redirect || !id_hold) state_d = S_REQ;
      S_DROP:  if (fire) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req  = req_en_q && (state_q != S_HOLD);
    imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  end

  always_comb begin
    pc_d        = pc_q;
    dpc4_d      = dpc4_q;
    inst_d      = inst_q;
    d_valid_d   = d_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc4_d   = buf_pc4_q;
    drop_addr_d = drop_addr_q;
    req_en_d    = 1'b1;
`ifdef DELAY_SLOT_EN
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
`endif
    if (!id_hold) begin
      inst_d    = NOP_INST;
      d_valid_d = 1'b0;
    end
    if (redirect && state_q == S_DROP) begin
      pc_d = target;
    end else if (redirect) begin
`ifdef DELAY_SLOT_EN
      // The slot word is either buffered, arriving now, or still to come.
      if (state_q == S_HOLD) begin
        inst_d    = buf_inst_q;
        dpc4_d    = buf_pc4_q;
        d_valid_d = 1'b1;
        pc_d      = target;
      end else if (fire) begin
        inst_d    = imem_rdata;
        dpc4_d    = pc_plus4;
        d_valid_d = 1'b1;
        pc_d      = target;
      end else begin
        pend_d     = 1'b1;
        pend_tgt_d = target;
      end
`else
      pc_d        = target;
      drop_addr_d = pc_q;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (fire) begin
            pc_d = pc_plus4;
`ifdef DELAY_SLOT_EN
            if (pend_q) begin
              pc_d   = pend_tgt_q;
              pend_d = 1'b0;
            end
`endif
            if (id_hold) begin
              buf_inst_d = imem_rdata;
              buf_pc4_d  = pc_plus4;
            end else begin
              inst_d    = imem_rdata;
              dpc4_d    = pc_plus4;
              d_valid_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!id_hold) begin
            inst_d    = buf_inst_q;
            dpc4_d    = buf_pc4_q;
            d_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign dpc4    = dpc4_q;
  assign inst    = inst_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Randomized scoreboard bench for pipeif_fetch: the model tracks program order
// (next address = previous + 4, or the redirect target) against a latency-varying memory.
module tb_pipeif_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
  logic        d_valid;

  pipeif_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .ra(ra),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .dpc4(dpc4), .inst(inst), .d_valid(d_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_addr = RESET_PC;
  logic [31:0] last_pop = 32'd0;
  bit prev_hold = 1'b0;
  bit wrap_seen = 1'b0;
  int new_count = 0;
  int lat_mode = 0;
  bit spurious_en = 1'b0;
  int stall_pct = 0;
  int redir_pct = 0;
  bit mem_busy = 1'b0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive decode-side inputs; a consumed IF/ID entry determines the next expected address.
  task automatic applyStimulus(input logic s, input logic [1:0] ps,
                               input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
    logic [31:0] nxt;
    stall = s; pcsource = ps; bpc = b; jpc = j; ra = r;
    if (clrn && d_valid && !s) begin
      case (ps)
        2'b00:   nxt = cur_addr + 32'd4;
        2'b01:   nxt = b;
        2'b10:   nxt = r;
        default: nxt = j;
      endcase
      exp_q.push_back(nxt & 32'hFFFF_FFFC);
    end
  endtask

  function automatic logic [31:0] randTarget();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 1023));
  endfunction

  task automatic randCycle();
    logic s;
    logic [1:0] ps;
    s  = (int'($urandom_range(0, 99)) < stall_pct);
    ps = (int'($urandom_range(0, 99)) < redir_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
    applyStimulus(s, ps, randTarget(), randTarget(), randTarget());
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk); #4;
      randCycle();
    end
  endtask

  // Memory: latency chosen per request, data derived from the address, spurious acks while idle.
  always @(posedge clk) begin
    #1;
    imem_ack = 1'b0;
    if (!imem_req) begin
      mem_busy = 1'b0;
      if (spurious_en && $urandom_range(0, 3) == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
      end
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        checkOutput("addr_align", 32'(imem_addr[1:0]), 32'd0);
      end else begin
        checkOutput("addr_stable", imem_addr, mem_addr);
      end
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] e;
    #2;
    if (clrn) begin
      if (d_valid) begin
        if (prev_hold) begin
          checkOutput("held_inst", inst, mem_word(cur_addr));
          checkOutput("held_dpc4", dpc4, cur_addr + 32'd4);
        end else begin
          checkOutput("sb_depth", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e == 32'd0 && last_pop == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            last_pop = e;
            cur_addr = e;
            checkOutput("inst", inst, mem_word(e));
            checkOutput("dpc4", dpc4, e + 32'd4);
            new_count++;
          end
        end
      end else begin
        if (prev_hold) checkOutput("hold_valid", 32'(d_valid), 32'd1);
        checkOutput("bubble_inst", inst, NOP_INST);
      end
    end
    #4;
    prev_hold = clrn && d_valid && stall;
  end

  initial begin
    int c0;
    bit found;
    clrn = 1'b0; stall = 1'b0; pcsource = 2'b00; bpc = 0; jpc = 0; ra = 0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #4;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_dpc4", dpc4, 32'd0);
    checkOutput("rst_inst", inst, NOP_INST);
    checkOutput("rst_valid", 32'(d_valid), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    exp_q.push_back(RESET_PC);
    @(negedge clk) clrn = 1'b1;

    runCycles(6);
    c0 = new_count;
    runCycles(10);
    checkOutput("zero_wait_rate", 32'(new_count - c0), 32'd10);

    @(posedge clk); #4;
    applyStimulus(1'b1, 2'b00, 0, 0, 0);
    checkOutput("stall_valid", 32'(d_valid), 32'd1);
    @(posedge clk); #4;
    applyStimulus(1'b1, 2'b00, 0, 0, 0);
    checkOutput("hold_req_low", 32'(imem_req), 32'd0);
    runCycles(3);

    @(posedge clk); #4;
    applyStimulus(1'b0, 2'b11, 0, 32'hFFFF_FFFB, 0);
    wrap_seen = 1'b0;
    runCycles(8);
    checkOutput("wrap_seen", 32'(wrap_seen), 32'd1);

    lat_mode = 3;
    runCycles(8);
    c0 = new_count;
    runCycles(16);
    checkOutput("lat3_rate", 32'(new_count - c0), 32'd4);

    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #4;
      if (d_valid) found = 1'b1;
      else applyStimulus(1'b0, 2'b00, 0, 0, 0);
    end
    checkOutput("wait_valid", 32'(found), 32'd1);
    applyStimulus(1'b0, 2'b11, 0, 32'h0000_0100, 0);
    @(posedge clk); #4;
    checkOutput("drop_pc", pc, 32'h0000_0100);
    checkOutput("drop_req", 32'(imem_req), 32'd1);
    checkOutput("drop_addr", imem_addr, cur_addr + 32'd4);
    applyStimulus(1'b0, 2'b00, 0, 0, 0);
    runCycles(12);

    lat_mode = -1; stall_pct = 30; redir_pct = 20; spurious_en = 1'b1;
    runCycles(1500);

    lat_mode = 3; stall_pct = 0; redir_pct = 0; spurious_en = 1'b0;
    runCycles(6);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #3;
      if (imem_req && !imem_ack) found = 1'b1;
      else begin #1; applyStimulus(1'b0, 2'b00, 0, 0, 0); end
    end
    checkOutput("wait_pending", 32'(found), 32'd1);
    clrn = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
    checkOutput("mid_rst_pc", pc, RESET_PC);
    checkOutput("mid_rst_valid", 32'(d_valid), 32'd0);
    checkOutput("mid_rst_inst", inst, NOP_INST);
    checkOutput("mid_rst_dpc4", dpc4, 32'd0);
    spurious_en = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    cur_addr = RESET_PC;
    stall = 1'b0; pcsource = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk) clrn = 1'b1;
    lat_mode = 0;
    runCycles(4);

    lat_mode = -1; stall_pct = 30; redir_pct = 20;
    runCycles(500);

    lat_mode = 0; stall_pct = 0; redir_pct = 0; spurious_en = 1'b0;
    runCycles(8);
    c0 = new_count;
    runCycles(10);
    checkOutput("final_rate", 32'(new_count - c0), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
